// File: rtl/sd_arb_pkg.sv
// sd_arb_pkg: shared types and constants for the SD request arbiter.
//   arb_state_t  per-channel FSM state
//   OWNER_A/B    requester identity (A = floppy controller, B = SD controller)
//   OP_RD/OP_WR  latched operation
//   pick_winner  round-robin choice between two simultaneous requesters
package sd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        REL  = 2'd3
    } arb_state_t;

    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

    localparam logic OP_RD = 1'b0;
    localparam logic OP_WR = 1'b1;

    // On a tie the requester that was not served last wins.
    function automatic logic pick_winner(input logic req_a,
                                         input logic req_b,
                                         input logic last_served);
        if (req_a && req_b) begin
            return ~last_served;
        end
        return req_b ? OWNER_B : OWNER_A;
    endfunction

endpackage

// File: rtl/sd_arb_chan.sv
// sd_arb_chan: one hps_io drive channel shared between requesters A and B.
// Ports:
//   CLK, RESET                 clock, synchronous active-high reset
//   a_lba/a_rd/a_wr/a_buff_din requester A request side; a_ack routed back
//   b_lba/b_rd/b_wr/b_buff_din requester B request side; b_ack routed back
//   sd_lba/sd_rd/sd_wr         latched request towards hps_io
//   sd_ack                     hps_io acknowledge
//   sd_buff_din                owner's sector buffer read data towards hps_io
//
// state | meaning
// IDLE  | no owner; accepts a request once sd_ack is low
// REQ   | strobe asserted with latched op/lba, waiting for sd_ack to rise
// XFER  | sector transfer in progress, waiting for sd_ack to fall
// REL   | one quiet cycle so the owner can drop its level request
module sd_arb_chan
    import sd_arb_pkg::*;
#(
    parameter int LBA_W = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [LBA_W-1:0] a_lba,
    input  logic             a_rd,
    input  logic             a_wr,
    output logic             a_ack,
    input  logic [7:0]       a_buff_din,
    input  logic [LBA_W-1:0] b_lba,
    input  logic             b_rd,
    input  logic             b_wr,
    output logic             b_ack,
    input  logic [7:0]       b_buff_din,
    output logic [LBA_W-1:0] sd_lba,
    output logic             sd_rd,
    output logic             sd_wr,
    input  logic             sd_ack,
    output logic [7:0]       sd_buff_din
);

    arb_state_t       state;
    logic             owner;
    logic             op;
    logic             last_served;
    logic [LBA_W-1:0] lba_q;

    logic             req_a;
    logic             req_b;
    logic             winner;
    logic             win_rd;
    logic [LBA_W-1:0] win_lba;
    logic             ack_live;

    always_comb begin
        req_a   = a_rd | a_wr;
        req_b   = b_rd | b_wr;
        winner  = pick_winner(req_a, req_b, last_served);
        win_rd  = (winner == OWNER_B) ? b_rd  : a_rd;
        win_lba = (winner == OWNER_B) ? b_lba : a_lba;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            owner       <= OWNER_A;
            op          <= OP_RD;
            last_served <= OWNER_B;
            lba_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A still-high sd_ack (e.g. reset mid-transfer) blocks acceptance.
                    if ((req_a || req_b) && !sd_ack) begin
                        owner       <= winner;
                        last_served <= winner;
                        // rd has priority; a concurrent wr stays pending for a later round.
                        op          <= win_rd ? OP_RD : OP_WR;
                        lba_q       <= win_lba;
                        state       <= REQ;
                    end
                end
                REQ: begin
                    if (sd_ack) begin
                        state <= XFER;
                    end
                end
                XFER: begin
                    if (!sd_ack) begin
                        state <= REL;
                    end
                end
                REL: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Strobes decode directly from the state register, so they drop on the
    // same edge that moves REQ -> XFER.
    assign sd_rd  = (state == REQ) && (op == OP_RD);
    assign sd_wr  = (state == REQ) && (op == OP_WR);
    assign sd_lba = lba_q;

    assign ack_live = ((state == REQ) || (state == XFER)) && sd_ack;
    assign a_ack    = ack_live && (owner == OWNER_A);
    assign b_ack    = ack_live && (owner == OWNER_B);

    assign sd_buff_din = (owner == OWNER_B) ? b_buff_din : a_buff_din;

endmodule

// File: rtl/sd_req_arb.sv
// sd_req_arb: shares the hps_io block-device channels between the floppy
// controller (A) and the SD controller (B). Each drive channel is arbitrated
// independently by its own sd_arb_chan.
// Ports:
//   CLK, RESET                          clock, synchronous active-high reset
//   a_lba/a_rd/a_wr/a_ack/a_buff_din    requester A, one slot per drive
//   b_lba/b_rd/b_wr/b_ack/b_buff_din    requester B, one slot per drive
//   sd_lba/sd_rd/sd_wr/sd_ack/sd_buff_din  hps_io side, one slot per drive
module sd_req_arb
    import sd_arb_pkg::*;
#(
    parameter int NUM_DRV = 2,
    parameter int LBA_W   = 32
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic [NUM_DRV-1:0][LBA_W-1:0] a_lba,
    input  logic [NUM_DRV-1:0]            a_rd,
    input  logic [NUM_DRV-1:0]            a_wr,
    output logic [NUM_DRV-1:0]            a_ack,
    input  logic [NUM_DRV-1:0][7:0]       a_buff_din,
    input  logic [NUM_DRV-1:0][LBA_W-1:0] b_lba,
    input  logic [NUM_DRV-1:0]            b_rd,
    input  logic [NUM_DRV-1:0]            b_wr,
    output logic [NUM_DRV-1:0]            b_ack,
    input  logic [NUM_DRV-1:0][7:0]       b_buff_din,
    output logic [NUM_DRV-1:0][LBA_W-1:0] sd_lba,
    output logic [NUM_DRV-1:0]            sd_rd,
    output logic [NUM_DRV-1:0]            sd_wr,
    input  logic [NUM_DRV-1:0]            sd_ack,
    output logic [NUM_DRV-1:0][7:0]       sd_buff_din
);

    for (genvar d = 0; d < NUM_DRV; d++) begin : g_chan
        sd_arb_chan #(
            .LBA_W (LBA_W)
        ) u_chan (
            .CLK         (CLK),
            .RESET       (RESET),
            .a_lba       (a_lba[d]),
            .a_rd        (a_rd[d]),
            .a_wr        (a_wr[d]),
            .a_ack       (a_ack[d]),
            .a_buff_din  (a_buff_din[d]),
            .b_lba       (b_lba[d]),
            .b_rd        (b_rd[d]),
            .b_wr        (b_wr[d]),
            .b_ack       (b_ack[d]),
            .b_buff_din  (b_buff_din[d]),
            .sd_lba      (sd_lba[d]),
            .sd_rd       (sd_rd[d]),
            .sd_wr       (sd_wr[d]),
            .sd_ack      (sd_ack[d]),
            .sd_buff_din (sd_buff_din[d])
        );
    end

endmodule

// File: tb/tb_sd_req_arb.sv
module tb_sd_req_arb;

    logic             CLK = 1'b0;
    logic             RESET;
    logic [1:0][31:0] a_lba, b_lba;
    logic [1:0]       a_rd, a_wr, b_rd, b_wr;
    logic [1:0]       a_ack, b_ack;
    logic [1:0][7:0]  a_buff_din, b_buff_din;
    logic [1:0][31:0] sd_lba;
    logic [1:0]       sd_rd, sd_wr, sd_ack;
    logic [1:0][7:0]  sd_buff_din;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    sd_req_arb #(.NUM_DRV(2), .LBA_W(32)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .a_lba       (a_lba),
        .a_rd        (a_rd),
        .a_wr        (a_wr),
        .a_ack       (a_ack),
        .a_buff_din  (a_buff_din),
        .b_lba       (b_lba),
        .b_rd        (b_rd),
        .b_wr        (b_wr),
        .b_ack       (b_ack),
        .b_buff_din  (b_buff_din),
        .sd_lba      (sd_lba),
        .sd_rd       (sd_rd),
        .sd_wr       (sd_wr),
        .sd_ack      (sd_ack),
        .sd_buff_din (sd_buff_din)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        chk("rst_strobes", {sd_rd, sd_wr}, 4'b0);
        chk("rst_acks", {a_ack, b_ack}, 4'b0);
        chk("rst_lba", sd_lba, 64'h0);
        RESET = 1'b0;
    endtask

    // Acts as hps_io for one transaction on drive d, then drops the served
    // strobe of the expected owner as the ack falls.
    task automatic serve(input int d, input logic own_b, input logic is_wr,
                         input logic [31:0] lba, input int dly, input int len);
        int n = 0;
        while (!(sd_rd[d] | sd_wr[d]) && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk("strobe_seen", 64'(n < 20), 64'h1);
        chk("op", {sd_wr[d], sd_rd[d]}, is_wr ? 2'b10 : 2'b01);
        chk("lba", sd_lba[d], lba);
        chk("buff", sd_buff_din[d], own_b ? b_buff_din[d] : a_buff_din[d]);
        repeat (dly) @(negedge CLK);
        chk("strobe_held", sd_rd[d] | sd_wr[d], 1'b1);
        sd_ack[d] = 1'b1;
        #1;
        chk("own_ack", own_b ? b_ack[d] : a_ack[d], 1'b1);
        chk("other_ack", own_b ? a_ack[d] : b_ack[d], 1'b0);
        repeat (len) begin
            @(negedge CLK);
            chk("strobe_off_xfer", sd_rd[d] | sd_wr[d], 1'b0);
            chk("ack_xfer", {a_ack[d], b_ack[d]}, own_b ? 2'b01 : 2'b10);
        end
        sd_ack[d] = 1'b0;
        if (own_b) begin
            if (is_wr) b_wr[d] = 1'b0; else b_rd[d] = 1'b0;
        end else begin
            if (is_wr) a_wr[d] = 1'b0; else a_rd[d] = 1'b0;
        end
        #1;
        chk("ack_fall", {a_ack[d], b_ack[d]}, 2'b00);
    endtask

    // Random-phase reference state (requester agents + hps responder).
    bit          pend [2][2];
    bit          rwr  [2][2];
    logic [31:0] rlba [2][2];
    bit          ppend[2][2];
    int          hst[2], hcnt[2];
    bit          tact[2], town[2], ls[2];
    int          ntx = 0;

    task automatic drive_req(input int d);
        a_rd[d]  = pend[d][0] && !rwr[d][0];
        a_wr[d]  = pend[d][0] &&  rwr[d][0];
        a_lba[d] = rlba[d][0];
        b_rd[d]  = pend[d][1] && !rwr[d][1];
        b_wr[d]  = pend[d][1] &&  rwr[d][1];
        b_lba[d] = rlba[d][1];
    endtask

    initial begin
        RESET = 1'b1;
        a_lba = '0; b_lba = '0; a_rd = '0; a_wr = '0; b_rd = '0; b_wr = '0;
        a_buff_din = '0; b_buff_din = '0; sd_ack = '0;

        // Single A read on drive 0.
        do_reset();
        a_buff_din[0] = 8'hA5;
        b_buff_din[0] = 8'h5B;
        a_lba[0] = 32'h123;
        a_rd[0]  = 1'b1;
        @(negedge CLK);
        chk("t1_rd_latency", sd_rd[0], 1'b1);
        serve(0, 1'b0, 1'b0, 32'h123, 3, 10);
        @(negedge CLK);
        chk("t1_rel_quiet", {sd_rd[0], sd_wr[0], a_ack[0]}, 3'b0);

        // Contention after reset: A wins, then B.
        do_reset();
        a_lba[0] = 32'hA00; a_rd[0] = 1'b1;
        b_lba[0] = 32'hB00; b_wr[0] = 1'b1;
        @(negedge CLK);
        serve(0, 1'b0, 1'b0, 32'hA00, 0, 2);
        @(negedge CLK);
        chk("t2_b_waits_rel", sd_wr[0], 1'b0);
        serve(0, 1'b1, 1'b1, 32'hB00, 1, 3);

        // Independent channels.
        repeat (3) @(negedge CLK);
        a_lba[0] = 32'h10; a_rd[0] = 1'b1;
        b_lba[1] = 32'h20; b_rd[1] = 1'b1;
        @(negedge CLK);
        chk("t3_lba", sd_lba, {32'h20, 32'h10});
        chk("t3_rd", sd_rd, 2'b11);
        sd_ack = 2'b11;
        #1;
        chk("t3_a_ack", a_ack, 2'b01);
        chk("t3_b_ack", b_ack, 2'b10);
        @(negedge CLK);
        sd_ack = 2'b00; a_rd[0] = 1'b0; b_rd[1] = 1'b0;
        repeat (3) @(negedge CLK);

        // B rd+wr together on drive 1: read first, then write.
        b_lba[1] = 32'h44; b_rd[1] = 1'b1; b_wr[1] = 1'b1;
        b_buff_din[1] = 8'h3C;
        @(negedge CLK);
        serve(1, 1'b1, 1'b0, 32'h44, 1, 2);
        serve(1, 1'b1, 1'b1, 32'h44, 1, 2);

        // Reset during XFER with a stale ack.
        repeat (3) @(negedge CLK);
        a_lba[0] = 32'h55; a_rd[0] = 1'b1;
        @(negedge CLK);
        sd_ack[0] = 1'b1;
        @(negedge CLK);
        chk("t5_xfer_ack", a_ack[0], 1'b1);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        chk("t5_rst_out", {sd_rd[0], sd_wr[0], a_ack[0], b_ack[0]}, 4'b0);
        chk("t5_rst_lba", sd_lba[0], 32'h0);
        repeat (4) begin
            @(negedge CLK);
            chk("t5_blocked", {sd_rd[0], a_ack[0]}, 2'b00);
        end
        sd_ack[0] = 1'b0;
        @(negedge CLK);
        chk("t5_accept_after_fall", sd_rd[0], 1'b1);
        serve(0, 1'b0, 1'b0, 32'h55, 0, 1);

        // B withdraws before ack.
        repeat (3) @(negedge CLK);
        b_lba[0] = 32'h66; b_rd[0] = 1'b1;
        @(negedge CLK);
        b_rd[0] = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            chk("t6_held", sd_rd[0], 1'b1);
        end
        serve(0, 1'b1, 1'b0, 32'h66, 0, 2);
        repeat (5) begin
            @(negedge CLK);
            chk("t6_no_rereq", {sd_rd[0], sd_wr[0]}, 2'b00);
        end

        // Random traffic against a transaction-level model.
        do_reset();
        for (int d = 0; d < 2; d++) begin
            hst[d] = 0; hcnt[d] = 0; tact[d] = 1'b0; town[d] = 1'b0; ls[d] = 1'b1;
            for (int r = 0; r < 2; r++) begin
                pend[d][r] = 1'b0; rwr[d][r] = 1'b0; rlba[d][r] = '0; ppend[d][r] = 1'b0;
            end
            drive_req(d);
        end
        for (int c = 0; c < 2100; c++) begin
            @(negedge CLK);
            for (int d = 0; d < 2; d++) begin
                if ((sd_rd[d] || sd_wr[d]) && !tact[d]) begin
                    bit w;
                    w = (ppend[d][0] && ppend[d][1]) ? !ls[d] : ppend[d][1];
                    chk("rnd_pending", 64'(ppend[d][0] || ppend[d][1]), 64'h1);
                    chk("rnd_lba", sd_lba[d], rlba[d][w]);
                    chk("rnd_op", {sd_wr[d], sd_rd[d]}, rwr[d][w] ? 2'b10 : 2'b01);
                    ls[d] = w; town[d] = w; tact[d] = 1'b1;
                    hst[d] = 1; hcnt[d] = int'($urandom_range(0, 3));
                    ntx++;
                end else if (tact[d] && hst[d] == 1) begin
                    chk("rnd_strobe_held", sd_rd[d] | sd_wr[d], 1'b1);
                end else begin
                    chk("rnd_strobe_off", sd_rd[d] | sd_wr[d], 1'b0);
                end
                chk("rnd_a_ack", a_ack[d], tact[d] && !town[d] && sd_ack[d]);
                chk("rnd_b_ack", b_ack[d], tact[d] &&  town[d] && sd_ack[d]);
                if (tact[d])
                    chk("rnd_buff", sd_buff_din[d], town[d] ? b_buff_din[d] : a_buff_din[d]);

                if (hst[d] == 1) begin
                    if (hcnt[d] == 0) begin
                        sd_ack[d] = 1'b1; hst[d] = 2; hcnt[d] = int'($urandom_range(1, 5));
                    end else hcnt[d]--;
                end else if (hst[d] == 2) begin
                    if (hcnt[d] == 0) begin
                        sd_ack[d] = 1'b0; hst[d] = 0; tact[d] = 1'b0;
                        pend[d][town[d]] = 1'b0;
                    end else hcnt[d]--;
                end

                for (int r = 0; r < 2; r++) begin
                    if (!pend[d][r] && c < 2000 && $urandom_range(0, 3) == 0) begin
                        logic [31:0] rv;
                        rv = $urandom;
                        pend[d][r] = 1'b1;
                        rwr[d][r]  = rv[31];
                        rlba[d][r] = {(r == 1), rv[30:0]};
                    end
                end
                drive_req(d);
                a_buff_din[d] = 8'($urandom);
                b_buff_din[d] = 8'($urandom);
                for (int r = 0; r < 2; r++) ppend[d][r] = pend[d][r];
            end
        end
        chk("rnd_drained", {pend[0][0], pend[0][1], pend[1][0], pend[1][1], 64'(hst[0] + hst[1])}, '0);
        chk("rnd_activity", 64'(ntx > 100), 64'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
